// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the ID/EX stage: ALU control codes, alu_op
// encodings, R-type funct values and the ID/EX pipeline register layout.
package mips_pkg;

    // ALU control codes presented to the ALU
    localparam logic [3:0] AluCtrlAdd     = 4'b0010;
    localparam logic [3:0] AluCtrlSub     = 4'b0110;
    localparam logic [3:0] AluCtrlAnd     = 4'b0000;
    localparam logic [3:0] AluCtrlOr      = 4'b0001;
    localparam logic [3:0] AluCtrlInvalid = 4'b1111;

    // Main-decoder alu_op encodings
    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10,
        AluOpOr    = 2'b11
    } alu_op_e;

    // R-type funct field values
    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;

    // ID/EX pipeline register; all-zero is the bubble encoding
    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  dest_addr;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        alu_src;
        logic        imm_zext;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } id_ex_t;

    // Widen a 16-bit immediate by zero or sign extension
    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic zext);
        logic [31:0] ext;
        ext = zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
        return ext;
    endfunction

endpackage

// File: rtl/alu_ctrl.sv
// ALU control decoder: maps alu_op and the R-type funct field to a 4-bit ALU code.
module alu_ctrl
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control
);

    // Decode alu_op; only the R-type class consults funct
    always_comb begin
        alu_control = AluCtrlInvalid;
        unique case (alu_op_e'(alu_op))
            AluOpAdd: alu_control = AluCtrlAdd;
            AluOpSub: alu_control = AluCtrlSub;
            AluOpOr:  alu_control = AluCtrlOr;
            AluOpFunct: begin
                case (funct)
                    FunctAdd: alu_control = AluCtrlAdd;
                    FunctSub: alu_control = AluCtrlSub;
                    FunctAnd: alu_control = AluCtrlAnd;
                    FunctOr:  alu_control = AluCtrlOr;
                    default:  alu_control = AluCtrlInvalid;
                endcase
            end
            default: alu_control = AluCtrlInvalid;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers decoded fields, resolves EX/MEM and MEM/WB
// forwarding, selects ALU operands and detects load-use hazards.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [1:0]  id_alu_op,
    input  logic [5:0]  id_funct,
    input  logic        id_alu_src,
    input  logic        id_imm_zext,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,

    input  logic        stall_in,
    input  logic        flush,

    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd_addr,
    input  logic [31:0] exm_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_data,

    output logic [31:0] alu_input1,
    output logic [31:0] alu_input2,
    output logic [3:0]  alu_control,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dest_addr,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        hazard_stall
);

    id_ex_t ex_q, ex_d, id_fields;
    logic [31:0] fwd_a, fwd_b;

    // Pack the decode inputs; destination is chosen here so EX sees one address
    always_comb begin
        id_fields            = '0;
        id_fields.valid      = id_valid;
        id_fields.rs_data    = id_rs_data;
        id_fields.rt_data    = id_rt_data;
        id_fields.imm        = id_imm;
        id_fields.rs_addr    = id_rs_addr;
        id_fields.rt_addr    = id_rt_addr;
        id_fields.dest_addr  = id_reg_dst ? id_rd_addr : id_rt_addr;
        id_fields.alu_op     = id_alu_op;
        id_fields.funct      = id_funct;
        id_fields.alu_src    = id_alu_src;
        id_fields.imm_zext   = id_imm_zext;
        id_fields.reg_write  = id_reg_write;
        id_fields.mem_read   = id_mem_read;
        id_fields.mem_write  = id_mem_write;
        id_fields.mem_to_reg = id_mem_to_reg;
    end

    // Load-use hazard: the load in EX writes a register the instruction in ID reads
    always_comb begin
        hazard_stall = ex_q.valid && ex_q.mem_read && (ex_q.dest_addr != 5'd0) && id_valid &&
                       ((ex_q.dest_addr == id_rs_addr) || (ex_q.dest_addr == id_rt_addr));
    end

    // Next-state priority: flush, then downstream hold, then hazard bubble, then load
    always_comb begin
        ex_d = id_fields;
        if (flush) begin
            ex_d = '0;
        end else if (stall_in) begin
            ex_d = ex_q;
        end else if (hazard_stall) begin
            ex_d = '0;
        end
    end

    // Pipeline register; reset value is the bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Operand forwarding; EX/MEM is the younger result so it wins, r0 never forwards
    always_comb begin
        fwd_a = ex_q.rs_data;
        if (exm_reg_write && (exm_rd_addr != 5'd0) && (exm_rd_addr == ex_q.rs_addr)) begin
            fwd_a = exm_result;
        end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_q.rs_addr)) begin
            fwd_a = wb_data;
        end

        fwd_b = ex_q.rt_data;
        if (exm_reg_write && (exm_rd_addr != 5'd0) && (exm_rd_addr == ex_q.rt_addr)) begin
            fwd_b = exm_result;
        end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_q.rt_addr)) begin
            fwd_b = wb_data;
        end
    end

    // Operand selection and EX outputs
    always_comb begin
        alu_input1    = fwd_a;
        alu_input2    = ex_q.alu_src ? extend_imm(ex_q.imm, ex_q.imm_zext) : fwd_b;
        ex_store_data = fwd_b;
        ex_dest_addr  = ex_q.dest_addr;
        ex_valid      = ex_q.valid;
        ex_reg_write  = ex_q.reg_write;
        ex_mem_read   = ex_q.mem_read;
        ex_mem_write  = ex_q.mem_write;
        ex_mem_to_reg = ex_q.mem_to_reg;
    end

    alu_ctrl u_alu_ctrl (
        .alu_op      (ex_q.alu_op),
        .funct       (ex_q.funct),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_id_ex_stage;

    logic        clk, rst_n;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_imm_zext, id_reg_dst, id_reg_write;
    logic        id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall_in, flush;
    logic        exm_reg_write, wb_reg_write;
    logic [4:0]  exm_rd_addr, wb_rd_addr;
    logic [31:0] exm_result, wb_data;
    logic [31:0] alu_input1, alu_input2, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_dest_addr;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        hazard_stall;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rd_addr(id_rd_addr), .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_imm_zext(id_imm_zext), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .stall_in(stall_in), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_control(alu_control),
        .ex_store_data(ex_store_data), .ex_dest_addr(ex_dest_addr), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .hazard_stall(hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction currently in EX (all-zero means bubble)
    logic        m_valid, m_src, m_zext, m_rw, m_mr, m_mw, m_m2r;
    logic [31:0] m_rs_data, m_rt_data;
    logic [15:0] m_imm;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [1:0]  m_op;
    logic [5:0]  m_funct;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_bubble();
        {m_valid, m_src, m_zext, m_rw, m_mr, m_mw, m_m2r} = '0;
        m_rs_data = '0; m_rt_data = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_dest = '0; m_op = '0; m_funct = '0;
    endtask

    function automatic logic exp_hazard();
        return m_valid && m_mr && m_dest != 0 && id_valid &&
               (m_dest == id_rs_addr || m_dest == id_rt_addr);
    endfunction

    function automatic logic [31:0] exp_fwd(input logic [4:0] a, input logic [31:0] d);
        if (a == 0) return d;
        if (exm_reg_write && exm_rd_addr == a) return exm_result;
        if (wb_reg_write && wb_rd_addr == a) return wb_data;
        return d;
    endfunction

    function automatic logic [3:0] exp_ctrl();
        if (m_op == 2'd0) return 4'd2;
        if (m_op == 2'd1) return 4'd6;
        if (m_op == 2'd3) return 4'd1;
        if (m_funct == 6'd32) return 4'd2;
        if (m_funct == 6'd34) return 4'd6;
        if (m_funct == 6'd36) return 4'd0;
        if (m_funct == 6'd37) return 4'd1;
        return 4'd15;
    endfunction

    function automatic logic [31:0] exp_in2();
        logic [31:0] ext;
        if (!m_src) return exp_fwd(m_rt, m_rt_data);
        ext = {16'd0, m_imm};
        if (!m_zext && m_imm >= 16'h8000) ext = ext + 32'hFFFF0000;
        return ext;
    endfunction

    // Apply one clock edge to the model, then advance past the edge
    task automatic clock();
        logic hz;
        @(posedge clk);
        hz = exp_hazard();
        if (flush || (!stall_in && hz)) begin
            model_bubble();
        end else if (!stall_in) begin
            m_valid = id_valid; m_rs_data = id_rs_data; m_rt_data = id_rt_data;
            m_imm = id_imm; m_rs = id_rs_addr; m_rt = id_rt_addr;
            m_dest = id_reg_dst ? id_rd_addr : id_rt_addr;
            m_op = id_alu_op; m_funct = id_funct; m_src = id_alu_src; m_zext = id_imm_zext;
            m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write; m_m2r = id_mem_to_reg;
        end
        #1;
    endtask

    task automatic compare_all(input string tag);
        check_value({tag, ".in1"}, alu_input1, exp_fwd(m_rs, m_rs_data));
        check_value({tag, ".in2"}, alu_input2, exp_in2());
        check_value({tag, ".ctrl"}, {28'd0, alu_control}, {28'd0, exp_ctrl()});
        check_value({tag, ".store"}, ex_store_data, exp_fwd(m_rt, m_rt_data));
        check_value({tag, ".dest"}, {27'd0, ex_dest_addr}, {27'd0, m_dest});
        check_value({tag, ".ctl"},
                    {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                    {27'd0, m_valid, m_rw, m_mr, m_mw, m_m2r});
        check_value({tag, ".haz"}, {31'd0, hazard_stall}, {31'd0, exp_hazard()});
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_alu_op = 0; id_funct = 0;
        id_alu_src = 0; id_imm_zext = 0; id_reg_dst = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        stall_in = 0; flush = 0;
        exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
        wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
    endtask

    // R-type instruction in decode
    task automatic set_rtype(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                             input logic [31:0] rtd, input logic [4:0] rd, input logic [5:0] fn);
        idle_inputs();
        id_valid = 1; id_rs_addr = rs; id_rs_data = rsd; id_rt_addr = rt; id_rt_data = rtd;
        id_rd_addr = rd; id_alu_op = 2'b10; id_funct = fn; id_reg_dst = 1; id_reg_write = 1;
    endtask

    // Load word into rt in decode
    task automatic set_lw(input logic [4:0] rt);
        idle_inputs();
        id_valid = 1; id_rs_addr = 5'd1; id_rs_data = 32'h100; id_rt_addr = rt;
        id_imm = 16'h4; id_alu_src = 1; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    endtask

    initial begin
        model_bubble();
        idle_inputs();
        rst_n = 0;
        #2;
        compare_all("reset");
        check_value("reset.ctrl_const", {28'd0, alu_control}, 32'h2);
        @(negedge clk);
        rst_n = 1;

        // add r?,r3,r4
        set_rtype(5'd3, 32'd5, 5'd4, 32'd7, 5'd10, 6'b100000);
        clock();
        @(negedge clk);
        compare_all("add");
        check_value("add.in1", alu_input1, 32'd5);
        check_value("add.in2", alu_input2, 32'd7);
        check_value("add.ctrl", {28'd0, alu_control}, 32'h2);
        check_value("add.dest", {27'd0, ex_dest_addr}, 32'd10);

        // Double forwarding match on rs=8
        set_rtype(5'd8, 32'h12345678, 5'd2, 32'd1, 5'd11, 6'b100010);
        clock();
        exm_reg_write = 1; exm_rd_addr = 8; exm_result = 32'hAAAA0000;
        wb_reg_write = 1; wb_rd_addr = 8; wb_data = 32'h11111111;
        @(negedge clk);
        compare_all("dbl");
        check_value("dbl.exm", alu_input1, 32'hAAAA0000);
        exm_reg_write = 0;
        #1;
        check_value("dbl.wb", alu_input1, 32'h11111111);
        set_rtype(5'd0, 32'h0000_0055, 5'd2, 32'd1, 5'd12, 6'b100100);
        clock();
        exm_reg_write = 1; exm_rd_addr = 0; exm_result = 32'hDEADBEEF;
        @(negedge clk);
        check_value("r0.nofwd", alu_input1, 32'h55);
        compare_all("r0");

        // Load-use hazard
        set_lw(5'd9);
        clock();
        set_rtype(5'd9, 32'd3, 5'd5, 32'd4, 5'd13, 6'b100000);
        @(negedge clk);
        check_value("lu.haz", {31'd0, hazard_stall}, 32'd1);
        clock();
        @(negedge clk);
        check_value("lu.bubble_valid", {31'd0, ex_valid}, 32'd0);
        check_value("lu.bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        check_value("lu.haz_clear", {31'd0, hazard_stall}, 32'd0);
        compare_all("lu");
        clock();
        @(negedge clk);
        check_value("lu.issue", {31'd0, ex_valid}, 32'd1);
        check_value("lu.issue_dest", {27'd0, ex_dest_addr}, 32'd13);

        // addi with negative immediate, then ori with zero extension
        idle_inputs();
        id_valid = 1; id_imm = 16'hFFFF; id_alu_src = 1; id_rt_addr = 5'd6; id_reg_write = 1;
        clock();
        @(negedge clk);
        check_value("addi.in2", alu_input2, 32'hFFFFFFFF);
        compare_all("addi");
        id_imm_zext = 1; id_alu_op = 2'b11;
        clock();
        @(negedge clk);
        check_value("ori.in2", alu_input2, 32'h0000FFFF);
        check_value("ori.ctrl", {28'd0, alu_control}, 32'h1);

        // flush together with stall_in
        set_rtype(5'd3, 32'd9, 5'd4, 32'd8, 5'd14, 6'b100101);
        clock();
        flush = 1; stall_in = 1;
        clock();
        @(negedge clk);
        check_value("flush.valid", {31'd0, ex_valid}, 32'd0);
        check_value("flush.in1", alu_input1, 32'd0);
        compare_all("flush");

        // stall_in alone holds for three cycles
        set_rtype(5'd3, 32'h33, 5'd4, 32'h44, 5'd15, 6'b100010);
        clock();
        set_rtype(5'd7, 32'h77, 5'd2, 32'h22, 5'd16, 6'b100000);
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            clock();
            @(negedge clk);
            check_value("hold.in1", alu_input1, 32'h33);
            check_value("hold.dest", {27'd0, ex_dest_addr}, 32'd15);
            compare_all("hold");
        end

        // hazard with stall_in: registers held
        set_lw(5'd9);
        clock();
        set_rtype(5'd9, 32'd1, 5'd9, 32'd2, 5'd17, 6'b100000);
        stall_in = 1;
        clock();
        @(negedge clk);
        check_value("hzst.mr", {31'd0, ex_mem_read}, 32'd1);
        check_value("hzst.dest", {27'd0, ex_dest_addr}, 32'd9);
        compare_all("hzst");
        stall_in = 0;
        clock();
        @(negedge clk);
        compare_all("hzst2");

        // Undefined funct
        set_rtype(5'd3, 32'd1, 5'd4, 32'd2, 5'd18, 6'b101010);
        clock();
        @(negedge clk);
        check_value("slt.ctrl", {28'd0, alu_control}, 32'hF);

        // Asynchronous reset between edges
        set_rtype(5'd3, 32'h5A, 5'd4, 32'hA5, 5'd19, 6'b100000);
        id_mem_write = 1;
        clock();
        #2;
        rst_n = 0;
        #1;
        model_bubble();
        check_value("arst.valid", {31'd0, ex_valid}, 32'd0);
        check_value("arst.in1", alu_input1, 32'd0);
        check_value("arst.ctrl", {28'd0, alu_control}, 32'h2);
        compare_all("arst");
        #1;
        rst_n = 1;
        clock();
        @(negedge clk);
        check_value("arst.reload", alu_input1, 32'h5A);
        compare_all("reload");

        // Randomized traffic with narrow register range to provoke matches
        for (int n = 0; n < 400; n++) begin
            clock();
            id_valid = 1'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
            id_imm = 16'($urandom); id_rs_addr = 5'($urandom_range(0, 7));
            id_rt_addr = 5'($urandom_range(0, 7)); id_rd_addr = 5'($urandom_range(0, 7));
            id_alu_op = 2'($urandom);
            id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(32 + 2 * $urandom_range(0, 2) +
                       ($urandom_range(0, 1) ? 0 : 5) * 0);
            if ($urandom_range(0, 4) == 0) id_funct = 6'b100101;
            if ($urandom_range(0, 4) == 0) id_funct = 6'b100100;
            id_alu_src = 1'($urandom); id_imm_zext = 1'($urandom); id_reg_dst = 1'($urandom);
            id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
            id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
            flush = ($urandom_range(0, 9) == 0); stall_in = ($urandom_range(0, 5) == 0);
            exm_reg_write = 1'($urandom); exm_rd_addr = 5'($urandom_range(0, 7));
            exm_result = $urandom;
            wb_reg_write = 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
            @(negedge clk);
            compare_all("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have decode inputs: id_valid 1; id_rs_data, id_rt_data 32; id_imm 16; id_rs_addr, id_rt_addr, id_rd_addr 5; id_alu_op 2; id_funct 6; id_alu_src, id_imm_zext, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg 1.
REQ-003 SHALL have control inputs: stall_in 1 (downstream hold) and flush 1 (branch squash).
REQ-004 SHALL have forwarding inputs: exm_reg_write 1, exm_rd_addr 5, exm_result 32 (EX/MEM); wb_reg_write 1, wb_rd_addr 5, wb_data 32 (MEM/WB).
REQ-005 SHALL have outputs: alu_input1, alu_input2 32 and alu_control 4 (to ALU); ex_store_data 32; ex_dest_addr 5; ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg 1; hazard_stall 1 (to fetch/decode).

Function
REQ-006 SHALL register all id_* fields on the rising clk edge; registered values SHALL drive outputs one cycle later (latency 1).
REQ-007 Per-edge priority SHALL be: flush > stall_in > hazard_stall > normal load.
REQ-008 flush=1 SHALL load a bubble: ex_valid and all ex_* control bits 0, data/address fields 0, alu_op=00, funct=0.
REQ-009 stall_in=1 (no flush) SHALL hold every register unchanged.
REQ-010 hazard_stall SHALL be combinational: ex_valid & ex_mem_read & ex_dest_addr!=0 & id_valid & (ex_dest_addr==id_rs_addr | ex_dest_addr==id_rt_addr).
REQ-011 hazard_stall=1 (no flush, no stall_in) SHALL load a bubble; decode is required to hold its inputs that cycle.
REQ-012 ex_dest_addr SHALL be registered id_rd_addr if id_reg_dst=1, else id_rt_addr.
REQ-013 Immediate SHALL be zero-extended if imm_zext=1, else sign-extended to 32 bits.
REQ-014 Forwarded operand A SHALL be: exm_result if exm_reg_write & exm_rd_addr!=0 & exm_rd_addr==rs_addr; else wb_data if wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==rs_addr; else registered rs_data. Operand B SHALL apply the same rule with rt.
REQ-015 EX/MEM match SHALL win over MEM/WB when both match; register 0 SHALL never be forwarded.
REQ-016 alu_input1 SHALL be forwarded A; alu_input2 SHALL be extended immediate if alu_src=1, else forwarded B; ex_store_data SHALL always be forwarded B.
REQ-017 alu_control SHALL decode from registered alu_op/funct: 00->0010; 01->0110; 11->0001; 10 with funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, other->1111.
REQ-018 Forwarding and alu_control SHALL be combinational from registered state and forwarding inputs (no extra latency).
REQ-019 Bubbles SHALL drive ex_reg_write, ex_mem_read, ex_mem_write=0 so no architectural side effect occurs.

Reset
REQ-020 rst_n=0 SHALL asynchronously clear all registers to bubble state, independent of clk.
REQ-021 During reset: ex_valid, all ex_* controls, ex_dest_addr, ex_store_data, alu_input1, alu_input2, hazard_stall=0; alu_control=0010.
REQ-022 Reset deassertion SHALL allow normal load at the first subsequent rising edge.

Structure
REQ-023 Shared package mips_pkg SHALL hold ALU control codes (ADD 0010, SUB 0110, AND 0000, OR 0001, INVALID 1111), alu_op encodings and R-type funct constants.
REQ-024 alu_control decode SHALL be one combinational sub-module alu_ctrl (inputs alu_op, funct; output alu_control); forwarding and hazard logic SHALL stay in id_ex_stage.

Verification
REQ-025 add: rs=3 (data 5), rt=4 (data 7), alu_op=10, funct=100000, no forwarding -> next cycle alu_input1=5, alu_input2=7, alu_control=0010, ex_dest_addr=rd.
REQ-026 Double match: ex rs=8, exm_rd=8 result 0xAAAA0000, wb_rd=8 data 0x11111111, both write -> alu_input1=0xAAAA0000; exm_reg_write=0 -> 0x11111111; rs=0 with exm_rd=0 -> registered data.
REQ-027 Load-use: EX holds lw to rt=9, ID rs=9 -> hazard_stall=1; next cycle ex_valid=0, ex_reg_write=0; then instruction issues with hazard_stall=0.
REQ-028 addi imm=0xFFFF, alu_src=1, imm_zext=0 -> alu_input2=0xFFFFFFFF; ori with imm_zext=1, alu_op=11 -> alu_input2=0x0000FFFF, alu_control=0001.
REQ-029 flush and stall_in both 1 -> bubble loaded; stall_in alone for 3 cycles -> outputs constant; hazard_stall with stall_in -> registers held.
REQ-030 rst_n asserted mid-stream between edges -> outputs immediately match REQ-021; funct 101010 with alu_op=10 -> alu_control=1111.
